alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the operand and result width.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have input in_valid, 1 bit: an operation is presented.
REQ-005 The block SHALL have output in_ready, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have input A, XLEN bits, operand 1.
REQ-007 The block SHALL have input B, XLEN bits, operand 2; B[4:0] is the shift amount for shifts.
REQ-008 The block SHALL have input ALUcontrol, 4 bits, the operation code from the ALU control stage.
REQ-009 The block SHALL have output out_valid, 1 bit: Result and Zero are valid.
REQ-010 The block SHALL have input out_ready, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have output Result, XLEN bits, the registered operation result.
REQ-012 The block SHALL have output Zero, 1 bit, high when Result equals 0.

Function
REQ-013 Op codes SHALL be 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed); codes 1001-1111 SHALL execute as ADD.
REQ-014 ADD/SUB SHALL be modulo 2^XLEN with the carry discarded; SLT SHALL yield 1 when signed A < signed B, else 0.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 An operation SHALL be accepted on a clock edge where in_valid and in_ready are both 1; A, B and ALUcontrol SHALL be captured then, and later input changes SHALL be ignored.
REQ-017 Non-shift ops, and shifts with B[4:0]=0, SHALL go IDLE->DONE with Result loaded at acceptance, so out_valid rises on the next cycle (latency 1).
REQ-018 Shifts with B[4:0]=N>0 SHALL go IDLE->SHIFT and shift 1 bit per cycle with a down-counter; after N SHIFT cycles the block SHALL enter DONE (latency N+1).
REQ-019 SRA SHALL replicate A[XLEN-1]; SLL and SRL SHALL insert zeros.
REQ-020 In DONE, out_valid SHALL be 1, and Result and Zero SHALL hold stable until out_ready=1, after which the block SHALL return to IDLE on that edge.
REQ-021 A new operation SHALL NOT be accepted in the same cycle as a result handoff; the minimum issue interval SHALL be 2 cycles.
REQ-022 out_valid SHALL be 0 in IDLE and SHIFT; Result SHALL hold its last value outside DONE.

Reset
REQ-023 While rst=1, the block SHALL be in IDLE with Result=0, Zero=1, out_valid=0, in_ready=0 and the shift counter at 0.
REQ-024 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the operation and discard the result without producing out_valid.

Structure
REQ-026 Op-code constants and the FSM state encoding SHALL live in a shared package, alu_pkg, which the ALU control stage also uses.
REQ-027 Single-cycle arithmetic and logic SHALL be in one combinational sub-module, alu_comb, instantiated once; the FSM, shift counter and output registers SHALL stay in alu_exec.

Verification
REQ-028 Bench: A=5, B=3, op 0001, out_ready=1 -> out_valid 1 cycle after acceptance, Result=2, Zero=0.
REQ-029 Bench: A=0x8000_0000, B=4, op 0111 -> out_valid 5 cycles after acceptance, Result=0xF800_0000, in_ready=0 throughout.
REQ-030 Bench: A=7, B=7, op 0100, out_ready held 0 for 3 cycles -> Result=0 and Zero=1 held stable with out_valid=1 for the full stall.
REQ-031 Bench: A=0xFFFF_FFFF (-1), B=1, op 1000 -> Result=1; op 1111 with A=1, B=2 -> Result=3.
REQ-032 Bench: rst pulsed 2 cycles into an SLL with B=20 -> out_valid never asserts, Result=0, and a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding and op classification helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SRL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_SLT = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    localparam int SHAMT_W = 5;

    // Shifts are the only ops that may take more than one cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub/logic/slt; shift ops pass A through (shift by zero).
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the output is captured.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] y
);

    // Op decode; undefined codes fall back to ADD, shifts return the unshifted operand.
    always_comb begin
        y = a + b;
        case (op)
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  y = a;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ops plus iterative 1-bit-per-cycle shifter with valid/ready handshakes.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, N+1 cycles for a shift by N.
// Backpressure: result holds in DONE until out_ready; in_ready is high only in IDLE.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUcontrol,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    alu_state_e           state;
    logic [XLEN-1:0]      shreg;
    logic [SHAMT_W-1:0]   cnt;
    logic [3:0]           op_q;
    logic [XLEN-1:0]      comb_y;
    logic                 accept;
    logic [XLEN-1:0]      shreg_next;

    alu_comb #(.XLEN(XLEN)) u_comb (
        .a  (A),
        .b  (B),
        .op (ALUcontrol),
        .y  (comb_y)
    );

    assign accept = in_valid & in_ready;
    assign Zero   = (Result == '0);

    // One-bit shift step for the captured op; SRA replicates the sign bit.
    always_comb begin
        shreg_next = {shreg[XLEN-2:0], 1'b0};
        case (op_q)
            OP_SRL:  shreg_next = {1'b0, shreg[XLEN-1:1]};
            OP_SRA:  shreg_next = {shreg[XLEN-1], shreg[XLEN-1:1]};
            default: shreg_next = {shreg[XLEN-2:0], 1'b0};
        endcase
    end

    // Control FSM with registered handshake outputs; Result only changes when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            Result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            op_q      <= OP_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        op_q     <= ALUcontrol;
                        in_ready <= 1'b0;
                        if (is_shift(ALUcontrol) && (B[SHAMT_W-1:0] != '0)) begin
                            shreg <= A;
                            cnt   <= B[SHAMT_W-1:0];
                            state <= ST_SHIFT;
                        end else begin
                            Result    <= comb_y;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == 1) begin
                        Result    <= shreg_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, reset-abort sequence, random ops vs reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls of several lengths.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUcontrol;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        int          stall;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[14];

    alu_exec #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUcontrol (ALUcontrol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the op-code table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int unsigned n;
        n = b[4:0];
        case (op)
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << n;
            4'd6:    return a >> n;
            4'd7:    return $signed(a) >>> n;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic [3:0] op);
        if ((op == 4'd5 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issue one op, measure latency, hold out_ready low for 'stall' cycles, then hand off.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input int stall, input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({tag, " in_ready_wait"}, in_ready, 1);
            return;
        end
        in_valid   = 1'b1;
        A          = a;
        B          = b;
        ALUcontrol = op;
        out_ready  = 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        A          = $urandom;
        B          = $urandom;
        ALUcontrol = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            check({tag, " in_ready_busy"}, in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " in_ready_done"}, in_ready, 0);
        check({tag, " result"}, Result, exp);
        check({tag, " zero"}, Zero, (exp == 32'd0));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall_valid"}, out_valid, 1);
            check({tag, " stall_result"}, Result, exp);
            check({tag, " stall_zero"}, Zero, (exp == 32'd0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_after_handoff"}, out_valid, 0);
        check({tag, " ready_after_handoff"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        A          = '0;
        B          = '0;
        ALUcontrol = '0;

        vt[0]  = '{32'd5,          32'd3,          4'b0001, 0, 32'd2,          1};
        vt[1]  = '{32'h8000_0000,  32'd4,          4'b0111, 0, 32'hF800_0000,  5};
        vt[2]  = '{32'd7,          32'd7,          4'b0100, 3, 32'd0,          1};
        vt[3]  = '{32'hFFFF_FFFF,  32'd1,          4'b1000, 0, 32'd1,          1};
        vt[4]  = '{32'd1,          32'd2,          4'b1111, 0, 32'd3,          1};
        vt[5]  = '{32'hFFFF_FFFF,  32'd1,          4'b0000, 0, 32'd0,          1};
        vt[6]  = '{32'd0,          32'd1,          4'b0001, 1, 32'hFFFF_FFFF,  1};
        vt[7]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0010, 0, 32'h00F0_00F0,  1};
        vt[8]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0011, 0, 32'hFFF0_FFF0,  1};
        vt[9]  = '{32'd1,          32'd31,         4'b0101, 0, 32'h8000_0000,  32};
        vt[10] = '{32'h8000_0000,  32'h0000_0020,  4'b0110, 0, 32'h8000_0000,  1};
        vt[11] = '{32'h8000_0000,  32'd31,         4'b0110, 2, 32'd1,          32};
        vt[12] = '{32'd2,          32'hFFFF_FFFF,  4'b1000, 0, 32'd0,          1};
        vt[13] = '{32'd10,         32'd20,         4'b1001, 0, 32'd30,         1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 1);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready_low", in_ready, 0);
        @(negedge clk);
        check("rst_release_in_ready_high", in_ready, 1);

        // Directed vector table.
        for (int i = 0; i < 14; i++)
            run_op(vt[i].a, vt[i].b, vt[i].op, vt[i].stall, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

        // Reset pulse two cycles into a long SLL.
        @(negedge clk);
        in_valid   = 1'b1;
        A          = 32'h0000_0001;
        B          = 32'd20;
        ALUcontrol = 4'b0101;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", Result, 0);
        check("abort_zero", Zero, 1);
        check("abort_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 0);
        check("abort_result_after", Result, 0);
        run_op(32'd1, 32'd1, 4'b0000, 0, 32'd2, 1, "post_abort_add");

        // Random ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'($urandom_range(0, 15));
            run_op(ra, rb, rop, $urandom_range(0, 2), model(ra, rb, rop), model_lat(rb, rop),
                   $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
